// File: rtl/spawn_collector.sv
// spawn_collector: gathers spawn requests from all processors over a req/ack
// handshake, serialises them round-robin into a small first-word-fall-through
// FIFO and presents the FIFO head to the dispatcher on a valid/ready port.
module spawn_collector #(
  parameter int unsigned PROC_CNT = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PROC_CNT-1:0]          spawn_req,
  input  logic [PROC_CNT*ADDR_W-1:0]   spawn_addr,
  output logic [PROC_CNT-1:0]          spawn_ack,
  output logic [ADDR_W-1:0]            q_data,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         idle,
  output logic                         overflow_err
);

  localparam int unsigned IdxW = $clog2(PROC_CNT);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PROC_CNT - 1);

  typedef enum logic [0:0] {StScan, StAck} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  // Set for the single SCAN cycle after ACK: the just-acked requester may
  // still show its request for one cycle and must not be granted again.
  logic                  mask_q;
  logic [PROC_CNT-1:0]   spawn_ack_q, spawn_ack_d;
  logic                  overflow_q, overflow_d;

  logic [ADDR_W-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [ADDR_W-1:0]     addr_arr [PROC_CNT];
  logic [IdxW-1:0]       cand;
  logic [IdxW-1:0]       grant_idx;
  logic                  grant_vld;
  logic                  push;
  logic                  pop;

  // Unpack the flat address bus into one entry per processor.
  for (genvar g = 0; g < PROC_CNT; g++) begin : gen_addr
    assign addr_arr[g] = spawn_addr[g*ADDR_W +: ADDR_W];
  end

  assign q_valid      = (count_q != '0);
  assign pop          = q_valid & q_ready;
  assign q_data       = q_valid ? mem_q[rd_ptr_q] : '0;
  assign pending      = count_q;
  assign spawn_ack    = spawn_ack_q;
  assign overflow_err = overflow_q;
  assign idle         = ~|spawn_req & (count_q == '0) & (state_q == StScan);

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < PROC_CNT; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % PROC_CNT);
      if (!grant_vld && spawn_req[cand] && !(mask_q && (cand == grant_q))) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state logic: grant and push in SCAN, pulse ack and check req in ACK.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    spawn_ack_d = '0;
    overflow_d  = overflow_q;
    push        = 1'b0;
    unique case (state_q)
      StScan: begin
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        if (grant_vld && ((count_q != DepthCnt) || pop)) begin
          push                   = 1'b1;
          grant_d                = grant_idx;
          rr_ptr_d               = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
          spawn_ack_d[grant_idx] = 1'b1;
          state_d                = StAck;
        end
      end
      StAck: begin
        if (!spawn_req[grant_q]) overflow_d = 1'b1;
        state_d = StScan;
      end
      default: state_d = StScan;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StScan;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mask_q      <= 1'b0;
      spawn_ack_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mask_q      <= (state_q == StAck);
      spawn_ack_q <= spawn_ack_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage; contents are only visible through q_data while valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= addr_arr[grant_idx];
  end

endmodule

// File: tb/tb_spawn_collector.sv
// Bench for spawn_collector: directed scenarios plus a randomized phase, with
// a transaction-level reference model and a queue-based data scoreboard.
module tb_spawn_collector;

  localparam int P  = 4;
  localparam int AW = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [P-1:0]    spawn_req = '0;
  logic [P*AW-1:0] spawn_addr;
  logic [P-1:0]    spawn_ack;
  logic [AW-1:0]   q_data;
  logic            q_valid;
  logic            q_ready = 1'b0;
  logic [CW-1:0]   pending;
  logic            idle;
  logic            overflow_err;

  logic [AW-1:0]   addr_r [P];

  spawn_collector #(.PROC_CNT(P), .ADDR_W(AW), .DEPTH(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .spawn_req    (spawn_req),
    .spawn_addr   (spawn_addr),
    .spawn_ack    (spawn_ack),
    .q_data       (q_data),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .pending      (pending),
    .idle         (idle),
    .overflow_err (overflow_err)
  );

  for (genvar g = 0; g < P; g++) begin : gen_bus
    assign spawn_addr[g*AW +: AW] = addr_r[g];
  end

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: occupancy, round-robin pointer, proc being acked
  // this cycle (-1 none), proc ignored for one scan (-1 none), sticky error.
  int  m_cnt, m_rr, m_acking, m_masked;
  bit  m_ovf;
  logic [AW-1:0] sb_q [$];
  logic [AW-1:0] exp_d;
  // Requester behaviour: >0 cycles until drop, -1 one cycle of rest after drop.
  int  drop_cnt [P];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a);
    addr_r[i]    = a;
    spawn_req[i] = 1'b1;
  endtask

  // One clock edge of the specified behaviour, applied to the inputs as driven.
  task automatic model_edge();
    bit pop;
    int g;
    int i;
    pop = (m_cnt > 0) && q_ready;
    g   = -1;
    if (m_acking >= 0) begin
      if (!spawn_req[m_acking]) m_ovf = 1'b1;
      m_masked = m_acking;
      m_acking = -1;
    end else begin
      if (m_cnt < D || pop) begin
        for (int k = 0; k < P; k++) begin
          i = (m_rr + k) % P;
          if (g < 0 && spawn_req[i] && i != m_masked) g = i;
        end
      end
      m_masked = -1;
      if (g >= 0) begin
        sb_q.push_back(addr_r[g]);
        m_cnt++;
        m_rr     = (g + 1) % P;
        m_acking = g;
      end
    end
    if (pop) m_cnt--;
  endtask

  // Advance one clock, check cycle-level outputs, then run requester handshakes.
  task automatic cycle();
    logic [P-1:0] e_ack;
    @(posedge clock);
    #1;
    model_edge();
    e_ack = '0;
    if (m_acking >= 0) e_ack[m_acking] = 1'b1;
    check("spawn_ack", 32'(spawn_ack), 32'(e_ack));
    check("pending", 32'(pending), m_cnt);
    check("q_valid", 32'(q_valid), 32'(m_cnt > 0));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("idle", 32'(idle), 32'(spawn_req == '0 && m_cnt == 0 && m_acking < 0));
    for (int i = 0; i < P; i++) begin
      if (drop_cnt[i] < 0) drop_cnt[i] = 0;
      else if (drop_cnt[i] > 0) begin
        drop_cnt[i]--;
        if (drop_cnt[i] == 0) begin
          spawn_req[i] = 1'b0;
          drop_cnt[i]  = -1;
        end
      end
    end
    if (m_acking >= 0) drop_cnt[m_acking] = 1 + int'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    spawn_req = '0;
    q_ready   = 1'b0;
    for (int i = 0; i < P; i++) drop_cnt[i] = 0;
    sb_q.delete();
    m_cnt = 0; m_rr = 0; m_acking = -1; m_masked = -1; m_ovf = 1'b0;
    @(posedge clock);
    #1;
    check("rst_ack", 32'(spawn_ack), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_q_data", 32'(q_data), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow_err), 0);
    check("rst_idle", 32'(idle), 1);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: every head transfer must match the next captured address.
  always @(negedge clock) begin
    if (reset_n && q_valid && q_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL q_data_unexpected: got %0h expected no entry at %0t", q_data, $time);
      end else begin
        exp_d = sb_q.pop_front();
        check("q_data", 32'(q_data), 32'(exp_d));
      end
    end
  end

  initial begin
    for (int i = 0; i < P; i++) addr_r[i] = '0;

    // Single request from proc 2.
    do_reset();
    set_req(2, 8'h5A);
    cycle();
    check("single_ack", 32'(spawn_ack), 32'h4);
    check("single_data", 32'(q_data), 32'h5A);
    run(2);
    q_ready = 1'b1;
    cycle();
    q_ready = 1'b0;
    cycle();
    check("single_idle", 32'(idle), 1);

    // Round-robin fairness from rr_ptr = 0.
    do_reset();
    for (int i = 0; i < P; i++) set_req(i, AW'(8'h10 + i));
    run(10);
    check("rr_pending_full", 32'(pending), 4);

    // Back-pressure while full, then one pop lets proc 1 in; drain.
    set_req(1, 8'h77);
    run(4);
    q_ready = 1'b1;
    cycle();
    q_ready = 1'b0;
    run(3);
    q_ready = 1'b1;
    run(6);
    q_ready = 1'b0;

    // Wrap: after granting proc 2, proc 3 beats proc 0.
    do_reset();
    set_req(2, 8'h42);
    run(4);
    set_req(0, 8'hA0);
    set_req(3, 8'hA3);
    cycle();
    check("wrap_ack", 32'(spawn_ack), 32'h8);
    run(5);
    q_ready = 1'b1;
    run(4);
    q_ready = 1'b0;

    // Fill, then push/pop together with q_ready held.
    do_reset();
    for (int i = 0; i < P; i++) set_req(i, AW'(8'h20 + i));
    run(9);
    q_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < P; i++)
        if (!spawn_req[i] && drop_cnt[i] == 0) set_req(i, AW'($urandom));
      cycle();
    end
    for (int i = 0; i < P; i++) drop_cnt[i] = (spawn_req[i] && drop_cnt[i] == 0) ? 0 : drop_cnt[i];
    q_ready = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      q_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < P; i++)
        if (!spawn_req[i] && drop_cnt[i] == 0 && $urandom_range(0, 3) == 0)
          set_req(i, AW'($urandom));
      cycle();
    end
    spawn_req = spawn_req;
    q_ready   = 1'b1;
    run(16);
    q_ready   = 1'b0;

    // Requester drops before ack completes: sticky overflow.
    do_reset();
    set_req(1, 8'h33);
    cycle();
    spawn_req[1] = 1'b0;
    drop_cnt[1]  = 0;
    cycle();
    check("ovf_set", 32'(overflow_err), 1);
    run(2);
    check("ovf_sticky", 32'(overflow_err), 1);

    // Asynchronous reset while in ACK.
    set_req(0, 8'h21);
    cycle();
    check("mid_ack_pulse", 32'(spawn_ack), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(spawn_ack), 0);
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_q_valid", 32'(q_valid), 0);
    check("mid_rst_overflow", 32'(overflow_err), 0);
    do_reset();
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
